// File: rtl/rec_frame_arb.sv
// Round-robin arbiter sharing one serial frame receiver between CH_NUM channels.
// Holds each grant until a CRC verdict, abort or timeout, then enforces an idle gap.
module rec_frame_arb #(
  parameter int CH_NUM     = 4,
  parameter int MAX_BITS   = 8192,
  parameter int START_TO   = 1024,
  parameter int VERDICT_TO = 4096,
  parameter int GAP_CYCLES = 16,
  localparam int CH_W      = $clog2(CH_NUM)
) (
  input  logic              i_clk20m,
  input  logic              i_rst,
  input  logic [CH_NUM-1:0] i_ch_req,
  input  logic [CH_NUM-1:0] i_ch_data,
  input  logic [CH_NUM-1:0] i_ch_en,
  output logic [CH_NUM-1:0] o_ch_gnt,
  output logic              o_data_in,
  output logic              o_data_en,
  input  logic              i_crc_ok,
  input  logic              i_crc_err,
  output logic              o_busy,
  output logic [CH_W-1:0]   o_cur_ch,
  output logic [15:0]       o_frame_ok_cnt,
  output logic [15:0]       o_frame_err_cnt,
  output logic [15:0]       o_timeout_cnt
);

  localparam int TMR_MAX = (VERDICT_TO > START_TO) ?
                           ((VERDICT_TO > GAP_CYCLES) ? VERDICT_TO : GAP_CYCLES) :
                           ((START_TO > GAP_CYCLES) ? START_TO : GAP_CYCLES);
  localparam int TMR_W = $clog2(TMR_MAX);
  localparam int BIT_W = $clog2(MAX_BITS);

  localparam logic [TMR_W-1:0] START_LAST   = TMR_W'(START_TO - 1);
  localparam logic [TMR_W-1:0] VERDICT_LAST = TMR_W'(VERDICT_TO - 1);
  localparam logic [TMR_W-1:0] GAP_LAST     = TMR_W'(GAP_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(MAX_BITS - 1);

  typedef enum logic [2:0] {IDLE, GRANT, XFER, WAIT_VERDICT, GAP} state_t;

  state_t           state;
  logic [TMR_W-1:0] tmr;
  logic [BIT_W-1:0] bit_cnt;
  logic             hit;
  logic [CH_W-1:0]  hit_idx;
  logic [CH_W-1:0]  cand;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Scan farthest-first so the channel nearest after o_cur_ch wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    cand    = '0;
    for (int i = CH_NUM; i >= 1; i--) begin
      cand = CH_W'((int'(o_cur_ch) + i) % CH_NUM);
      if (i_ch_req[cand]) begin
        hit     = 1'b1;
        hit_idx = cand;
      end
    end
  end

  always_ff @(posedge i_clk20m or posedge i_rst) begin
    if (i_rst) begin
      state           <= IDLE;
      o_ch_gnt        <= '0;
      o_data_in       <= 1'b0;
      o_data_en       <= 1'b0;
      o_busy          <= 1'b0;
      o_cur_ch        <= CH_W'(CH_NUM - 1);
      o_frame_ok_cnt  <= '0;
      o_frame_err_cnt <= '0;
      o_timeout_cnt   <= '0;
      tmr             <= '0;
      bit_cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            state    <= GRANT;
            o_ch_gnt <= CH_NUM'(1) << hit_idx;
            o_cur_ch <= hit_idx;
            o_busy   <= 1'b1;
            tmr      <= '0;
            bit_cnt  <= '0;
          end
        end

        // The first bit is forwarded on the same edge that sees enable rise.
        GRANT: begin
          if (i_ch_en[o_cur_ch]) begin
            state     <= XFER;
            o_data_en <= 1'b1;
            o_data_in <= i_ch_data[o_cur_ch];
            tmr       <= '0;
            bit_cnt   <= '0;
          end else if (!i_ch_req[o_cur_ch]) begin
            state    <= GAP;
            o_ch_gnt <= '0;
            tmr      <= '0;
            bit_cnt  <= '0;
          end else if (tmr == START_LAST) begin
            state         <= GAP;
            o_ch_gnt      <= '0;
            o_timeout_cnt <= sat_inc(o_timeout_cnt);
            tmr           <= '0;
            bit_cnt       <= '0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        XFER: begin
          if (!i_ch_en[o_cur_ch]) begin
            state     <= WAIT_VERDICT;
            o_data_en <= 1'b0;
            o_data_in <= 1'b0;
            tmr       <= '0;
            bit_cnt   <= '0;
          end else if (bit_cnt == BIT_LAST) begin
            state           <= GAP;
            o_ch_gnt        <= '0;
            o_data_en       <= 1'b0;
            o_data_in       <= 1'b0;
            o_frame_err_cnt <= sat_inc(o_frame_err_cnt);
            tmr             <= '0;
            bit_cnt         <= '0;
          end else begin
            o_data_en <= 1'b1;
            o_data_in <= i_ch_data[o_cur_ch];
            bit_cnt   <= bit_cnt + 1'b1;
          end
        end

        // A simultaneous ok+err pair is treated as an error.
        WAIT_VERDICT: begin
          if (i_crc_err) begin
            state           <= GAP;
            o_ch_gnt        <= '0;
            o_frame_err_cnt <= sat_inc(o_frame_err_cnt);
            tmr             <= '0;
            bit_cnt         <= '0;
          end else if (i_crc_ok) begin
            state          <= GAP;
            o_ch_gnt       <= '0;
            o_frame_ok_cnt <= sat_inc(o_frame_ok_cnt);
            tmr            <= '0;
            bit_cnt        <= '0;
          end else if (tmr == VERDICT_LAST) begin
            state         <= GAP;
            o_ch_gnt      <= '0;
            o_timeout_cnt <= sat_inc(o_timeout_cnt);
            tmr           <= '0;
            bit_cnt       <= '0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        GAP: begin
          if (tmr == GAP_LAST) begin
            state   <= IDLE;
            o_busy  <= 1'b0;
            tmr     <= '0;
            bit_cnt <= '0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          o_ch_gnt  <= '0;
          o_data_en <= 1'b0;
          o_data_in <= 1'b0;
          o_busy    <= 1'b0;
          tmr       <= '0;
          bit_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rec_frame_arb.sv
// Randomized bench for rec_frame_arb: drives frames on granted channels and
// compares grants, forwarded bits and status counters against a rule-level model.
module tb_rec_frame_arb;

  localparam int CH_NUM     = 4;
  localparam int MAX_BITS   = 8192;
  localparam int START_TO   = 1024;
  localparam int VERDICT_TO = 4096;
  localparam int GAP_CYCLES = 16;
  localparam int CH_W       = $clog2(CH_NUM);

  logic              i_clk20m = 1'b0;
  logic              i_rst = 1'b1;
  logic [CH_NUM-1:0] i_ch_req;
  logic [CH_NUM-1:0] i_ch_data;
  logic [CH_NUM-1:0] i_ch_en;
  logic [CH_NUM-1:0] o_ch_gnt;
  logic              o_data_in;
  logic              o_data_en;
  logic              i_crc_ok;
  logic              i_crc_err;
  logic              o_busy;
  logic [CH_W-1:0]   o_cur_ch;
  logic [15:0]       o_frame_ok_cnt;
  logic [15:0]       o_frame_err_cnt;
  logic [15:0]       o_timeout_cnt;

  rec_frame_arb #(
    .CH_NUM(CH_NUM), .MAX_BITS(MAX_BITS), .START_TO(START_TO),
    .VERDICT_TO(VERDICT_TO), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .i_clk20m(i_clk20m), .i_rst(i_rst),
    .i_ch_req(i_ch_req), .i_ch_data(i_ch_data), .i_ch_en(i_ch_en),
    .o_ch_gnt(o_ch_gnt), .o_data_in(o_data_in), .o_data_en(o_data_en),
    .i_crc_ok(i_crc_ok), .i_crc_err(i_crc_err), .o_busy(o_busy),
    .o_cur_ch(o_cur_ch), .o_frame_ok_cnt(o_frame_ok_cnt),
    .o_frame_err_cnt(o_frame_err_cnt), .o_timeout_cnt(o_timeout_cnt)
  );

  always #25 i_clk20m = ~i_clk20m;

  int checks = 0;
  int errors = 0;
  int exp_ok, exp_err, exp_to, last_ch;
  int zero_run = 0;
  int last_gap = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Length of the most recent run of cycles with no grant.
  always @(negedge i_clk20m) begin
    if (i_rst) zero_run = 0;
    else if (o_ch_gnt == '0) zero_run++;
    else if (zero_run != 0) begin
      last_gap = zero_run;
      zero_run = 0;
    end
  end

  function automatic int rr_next(input int last, input logic [CH_NUM-1:0] req);
    int res;
    bit found;
    res = 0;
    found = 0;
    for (int i = 1; i <= CH_NUM; i++) begin
      if (!found && req[(last + i) % CH_NUM]) begin
        res = (last + i) % CH_NUM;
        found = 1;
      end
    end
    return res;
  endfunction

  task automatic check_counters(input string tag);
    checkOutput({tag, "_ok_cnt"}, o_frame_ok_cnt, exp_ok);
    checkOutput({tag, "_err_cnt"}, o_frame_err_cnt, exp_err);
    checkOutput({tag, "_to_cnt"}, o_timeout_cnt, exp_to);
  endtask

  task automatic wait_grant(input int bound, input int exp_ch, input bit chk_gap);
    int n;
    n = 0;
    do begin
      @(negedge i_clk20m);
      n++;
    end while (o_ch_gnt == '0 && n < bound);
    checkOutput("grant_wait_expired", o_ch_gnt == '0, 0);
    checkOutput("grant", o_ch_gnt, CH_NUM'(1) << exp_ch);
    checkOutput("cur_ch", o_cur_ch, exp_ch);
    #1;
    if (chk_gap) checkOutput("gap_at_least_min", last_gap >= GAP_CYCLES, 1);
    last_ch = exp_ch;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    do begin
      @(negedge i_clk20m);
      n++;
    end while (o_busy && n < bound);
    checkOutput("idle_wait", o_busy, 0);
  endtask

  task automatic set_noise(input int ch, input bit active);
    for (int c = 0; c < CH_NUM; c++) begin
      if (c != ch && !i_ch_req[c]) begin
        i_ch_en[c]   = active ? 1'($urandom) : 1'b0;
        i_ch_data[c] = active ? 1'($urandom) : 1'b0;
      end
    end
  endtask

  // Drives a len-bit frame on ch; counts cycles where the forwarded bit differs
  // from what the granted channel presented one cycle earlier.
  task automatic applyStimulus(input int ch, input int len, input logic [7:0] pat,
                               input bit use_pat, input int drop_at, output int mism);
    logic exp_en, exp_d, b;
    exp_en = 1'b0;
    exp_d  = 1'b0;
    mism   = 0;
    for (int k = 0; k <= len; k++) begin
      @(negedge i_clk20m);
      if (o_data_en !== exp_en || o_data_in !== exp_d) mism++;
      if (k < len) begin
        b = use_pat ? pat[7 - (k % 8)] : 1'($urandom);
        i_ch_en[ch]   = 1'b1;
        i_ch_data[ch] = b;
        exp_en = (k < MAX_BITS);
        exp_d  = exp_en ? b : 1'b0;
      end else begin
        i_ch_en[ch]   = 1'b0;
        i_ch_data[ch] = 1'b0;
        exp_en = 1'b0;
        exp_d  = 1'b0;
      end
      if (k == drop_at) i_ch_req[ch] = 1'b0;
      i_crc_ok  = (k > 0 && k < len) && ($urandom_range(0, 15) == 0);
      i_crc_err = (k > 0 && k < len) && ($urandom_range(0, 15) == 0);
      set_noise(ch, 1'b1);
    end
    @(negedge i_clk20m);
    if (o_data_en !== exp_en || o_data_in !== exp_d) mism++;
    set_noise(ch, 1'b0);
  endtask

  // kind: 0 ok, 1 err, 2 ok+err together, 3 no verdict
  task automatic send_verdict(input int kind, input int delay);
    repeat (delay) @(negedge i_clk20m);
    i_crc_ok  = (kind == 0 || kind == 2);
    i_crc_err = (kind == 1 || kind == 2);
    @(negedge i_clk20m);
    i_crc_ok  = 1'b0;
    i_crc_err = 1'b0;
    case (kind)
      0:       exp_ok++;
      1, 2:    exp_err++;
      default: exp_to++;
    endcase
  endtask

  initial begin
    int ch, mism, len, kind;
    i_rst = 1'b1;
    i_ch_req = '0;
    i_ch_data = '0;
    i_ch_en = '0;
    i_crc_ok = 1'b0;
    i_crc_err = 1'b0;
    exp_ok = 0;
    exp_err = 0;
    exp_to = 0;
    last_ch = CH_NUM - 1;

    repeat (3) @(negedge i_clk20m);
    checkOutput("rst_gnt", o_ch_gnt, 0);
    checkOutput("rst_data_in", o_data_in, 0);
    checkOutput("rst_data_en", o_data_en, 0);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_cur_ch", o_cur_ch, CH_NUM - 1);
    check_counters("rst");
    i_rst = 1'b0;

    $display("[TB] round-robin with all channels requesting");
    i_ch_req = '1;
    for (int n = 0; n < 5; n++) begin
      ch = rr_next(last_ch, i_ch_req);
      wait_grant(200, ch, n > 0);
      if (n == 4) i_ch_req = CH_NUM'(1) << ch;
      applyStimulus(ch, 100, 8'h00, 1'b0, (n == 4) ? 100 : -1, mism);
      checkOutput("rr_datapath_mism", mism, 0);
      send_verdict(0, 49);
      wait_idle(6000);
    end
    check_counters("rr");

    $display("[TB] datapath 0xA5 on ch2 with neighbour noise");
    i_ch_req = CH_NUM'(1) << 2;
    ch = rr_next(last_ch, i_ch_req);
    wait_grant(200, ch, 1'b1);
    applyStimulus(ch, 8, 8'hA5, 1'b1, 8, mism);
    checkOutput("a5_datapath_mism", mism, 0);
    send_verdict(1, 10);
    wait_idle(6000);
    check_counters("crc_err");

    $display("[TB] start timeout on ch1");
    i_ch_req = (CH_NUM'(1) << 1) | (CH_NUM'(1) << 2);
    ch = rr_next(last_ch, i_ch_req);
    wait_grant(200, ch, 1'b1);
    repeat (START_TO - 1) @(negedge i_clk20m);
    checkOutput("start_to_hold", o_ch_gnt, CH_NUM'(1) << ch);
    @(negedge i_clk20m);
    checkOutput("start_to_release", o_ch_gnt, 0);
    exp_to++;
    checkOutput("start_to_cnt", o_timeout_cnt, exp_to);
    i_ch_req[ch] = 1'b0;

    ch = rr_next(last_ch, i_ch_req);
    wait_grant(200, ch, 1'b1);
    i_ch_req[3] = 1'b1;
    applyStimulus(ch, 40, 8'h00, 1'b0, 40, mism);
    checkOutput("both_datapath_mism", mism, 0);
    send_verdict(2, 5);
    wait_idle(6000);
    check_counters("ok_and_err");

    $display("[TB] verdict timeout");
    ch = rr_next(last_ch, i_ch_req);
    wait_grant(200, ch, 1'b1);
    applyStimulus(ch, 30, 8'h00, 1'b0, 30, mism);
    checkOutput("vto_datapath_mism", mism, 0);
    send_verdict(3, 0);
    wait_idle(VERDICT_TO + 200);
    check_counters("verdict_to");

    $display("[TB] overflow with enable held past the bit limit");
    i_ch_req = CH_NUM'(1);
    ch = rr_next(last_ch, i_ch_req);
    wait_grant(200, ch, 1'b1);
    applyStimulus(ch, 9000, 8'h00, 1'b0, 1, mism);
    checkOutput("ovf_datapath_mism", mism, 0);
    exp_err++;
    wait_idle(200);
    check_counters("overflow");
    repeat (5) @(negedge i_clk20m);
    checkOutput("ovf_no_regrant", o_ch_gnt, 0);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 16; t++) begin
      if (i_ch_req == '0) i_ch_req = CH_NUM'($urandom_range(1, (1 << CH_NUM) - 1));
      ch = rr_next(last_ch, i_ch_req);
      wait_grant(200, ch, 1'b1);
      i_ch_req = CH_NUM'($urandom) | (CH_NUM'(1) << ch);
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(0, 10)) @(negedge i_clk20m);
        i_ch_req[ch] = 1'b0;
      end else begin
        len = $urandom_range(1, 150);
        applyStimulus(ch, len, 8'h00, 1'b0, ($urandom_range(0, 1) == 1) ? -1 : len, mism);
        checkOutput("rand_datapath_mism", mism, 0);
        kind = $urandom_range(0, 2);
        send_verdict(kind, $urandom_range(0, 40));
      end
      wait_idle(6000);
      check_counters("rand");
    end

    $display("[TB] reset in the middle of a frame");
    i_ch_req = '1;
    ch = rr_next(last_ch, i_ch_req);
    wait_grant(200, ch, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk20m);
      i_ch_en[ch] = 1'b1;
      i_ch_data[ch] = 1'($urandom);
    end
    @(negedge i_clk20m);
    i_rst = 1'b1;
    #1;
    checkOutput("midrst_data_en", o_data_en, 0);
    checkOutput("midrst_data_in", o_data_in, 0);
    checkOutput("midrst_gnt", o_ch_gnt, 0);
    checkOutput("midrst_busy", o_busy, 0);
    checkOutput("midrst_cur_ch", o_cur_ch, CH_NUM - 1);
    exp_ok = 0;
    exp_err = 0;
    exp_to = 0;
    check_counters("midrst");
    @(negedge i_clk20m);
    i_ch_en = '0;
    i_ch_data = '0;
    @(negedge i_clk20m);
    i_rst = 1'b0;
    last_ch = CH_NUM - 1;
    wait_grant(200, rr_next(last_ch, i_ch_req), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
